// File: rtl/plat_color_gen_pkg.sv
// Shared encodings and reset layout for the platform/colour generator.
// Latency: n/a (constants only); no backpressure.
package plat_color_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOLOR = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [1:0]  STROBE_UPDATE = 2'b11;
  localparam logic [2:0]  BG_COLOR      = 3'b000;
  localparam logic [2:0]  BG_REMAP      = 3'b111;

  // Lane 0 occupies the least significant slice.
  localparam logic [27:0] RST_POS  = {7'd95, 7'd70, 7'd45, 7'd20};
  localparam logic [11:0] RST_COL  = {3'b110, 3'b100, 3'b010, 3'b001};
  localparam logic [2:0]  RST_BALL = 3'b001;

  // A platform drawn in the background colour would be invisible.
  function automatic logic [2:0] visible_color(input logic [2:0] c);
    return (c == BG_COLOR) ? BG_REMAP : c;
  endfunction

endpackage

// File: rtl/plat_color_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running from SEED.
// Latency: one step per clock; no backpressure.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {fb, q[15:1]};
  end

endmodule

// File: rtl/plat_color_gen.sv
// Platform lane positions/colours and ball colour for the bounce updater.
// Latency: 1 cycle per scroll step, 4 cycles per recolour; no backpressure.
module plat_color_gen
  import plat_color_gen_pkg::*;
#(
  parameter int                POS_W      = 7,
  parameter int                COL_W      = 3,
  parameter logic [POS_W-1:0]  POS_MAX    = 7'd116,
  parameter int                SCROLL_DIV = 4,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           statesig,
  input  logic                 start,
  input  logic                 touch,
  input  logic                 gameover,
  output logic [4*POS_W-1:0]   position_plats,
  output logic [4*POS_W-1:0]   prev_plats,
  output logic [4*COL_W-1:0]   color_plats,
  output logic [COL_W-1:0]     color_ball,
  output logic                 colors_valid
);

  localparam int               DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  state_t             state, state_nxt;
  logic [15:0]        lfsr;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         rc_idx;
  logic               strobe, scroll_en, start_rc, rc_write, rc_done, go_hold, reload;
  logic [4*POS_W-1:0] pos_dec;
  logic [COL_W-1:0]   new_col, ball_pick;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign strobe  = (statesig == STROBE_UPDATE);
  assign new_col = visible_color(lfsr[2:0]);
  // Lane 3 is written on the same edge as the ball, so take its fresh value.
  assign ball_pick = (lfsr[4:3] == 2'd3) ? new_col : color_plats[lfsr[4:3]*COL_W +: COL_W];

  always_comb begin
    pos_dec = '0;
    for (int i = 0; i < 4; i++) begin
      if (position_plats[i*POS_W +: POS_W] == '0)
        pos_dec[i*POS_W +: POS_W] = POS_MAX;
      else
        pos_dec[i*POS_W +: POS_W] = position_plats[i*POS_W +: POS_W] - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scroll_en = 1'b0;
    start_rc  = 1'b0;
    rc_write  = 1'b0;
    rc_done   = 1'b0;
    go_hold   = 1'b0;
    reload    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (gameover) begin
          state_nxt = ST_HOLD;
          go_hold   = 1'b1;
        end else begin
          scroll_en = strobe;
          if (touch) begin
            state_nxt = ST_RECOLOR;
            start_rc  = 1'b1;
          end
        end
      end
      ST_RECOLOR: begin
        if (gameover) begin
          state_nxt = ST_HOLD;
          go_hold   = 1'b1;
        end else begin
          scroll_en = strobe;
          rc_write  = 1'b1;
          if (rc_idx == 2'd3) begin
            state_nxt = ST_RUN;
            rc_done   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (start && !gameover) begin
          state_nxt = ST_RUN;
          reload    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position_plats <= (4*POS_W)'(RST_POS);
      prev_plats     <= (4*POS_W)'(RST_POS);
      color_plats    <= (4*COL_W)'(RST_COL);
      color_ball     <= COL_W'(RST_BALL);
      colors_valid   <= 1'b1;
      div_cnt        <= '0;
      rc_idx         <= '0;
    end else begin
      if (reload) begin
        position_plats <= (4*POS_W)'(RST_POS);
        prev_plats     <= (4*POS_W)'(RST_POS);
        color_plats    <= (4*COL_W)'(RST_COL);
        color_ball     <= COL_W'(RST_BALL);
        colors_valid   <= 1'b1;
        div_cnt        <= '0;
        rc_idx         <= '0;
      end
      if (go_hold) colors_valid <= 1'b1;
      if (scroll_en) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt        <= '0;
          prev_plats     <= position_plats;
          position_plats <= pos_dec;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
      if (start_rc) begin
        rc_idx       <= '0;
        colors_valid <= 1'b0;
      end
      if (rc_write) begin
        color_plats[rc_idx*COL_W +: COL_W] <= new_col;
        rc_idx                             <= rc_idx + 2'd1;
        if (rc_done) begin
          color_ball   <= ball_pick;
          colors_valid <= 1'b1;
        end
      end
    end
  end

endmodule
